// File: rtl/dp_share_sequencer.sv
// Round-robin sequencer sharing one register-file/ALU datapath between two requesters.
// Runs a fixed read-A / read-B / execute / write-back / ack micro-sequence per grant.
module dp_share_sequencer #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [SEL_W-1:0] src_a0,
    input  logic [SEL_W-1:0] src_b0,
    input  logic [SEL_W-1:0] dst0,
    input  logic             fn0,
    input  logic             req1,
    input  logic [SEL_W-1:0] src_a1,
    input  logic [SEL_W-1:0] src_b1,
    input  logic [SEL_W-1:0] dst1,
    input  logic             fn1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             gnt_id,
    output logic             l1,
    output logic             l4,
    output logic             l2,
    output logic             l3,
    output logic             r,
    output logic             w,
    output logic             f,
    output logic [SEL_W-1:0] s1,
    output logic [SEL_W-1:0] s2
);

    typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, WB, ACK} state_t;

    state_t           state, state_nxt;
    logic             last_gnt;
    logic             gnt_q;
    logic [SEL_W-1:0] src_a_q, src_b_q, dst_q;
    logic             fn_q;
    logic             any_req;
    logic             winner;

    // On a tie the requester that did not win last time takes the datapath.
    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 && req1) ? ~last_gnt : req1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LD_A;
            LD_A:    state_nxt = LD_B;
            LD_B:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            fn_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                gnt_q   <= winner;
                src_a_q <= winner ? src_a1 : src_a0;
                src_b_q <= winner ? src_b1 : src_b0;
                dst_q   <= winner ? dst1   : dst0;
                fn_q    <= winner ? fn1    : fn0;
            end
            if (state == ACK) last_gnt <= gnt_q;
        end
    end

    // Moore decode: outputs depend only on state and the latched operands.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ack0   = 1'b0;
        ack1   = 1'b0;
        busy   = (state != IDLE);
        gnt_id = gnt_q;
        l1     = 1'b0;
        l4     = 1'b0;
        l2     = 1'b0;
        l3     = 1'b0;
        r      = 1'b0;
        w      = 1'b0;
        f      = 1'b0;
        s1     = '0;
        s2     = '0;
        case (state)
            LD_A: begin
                r  = 1'b1;
                l1 = 1'b1;
                s1 = src_a_q;
            end
            LD_B: begin
                r  = 1'b1;
                l4 = 1'b1;
                s1 = src_b_q;
            end
            EXEC: begin
                l2 = 1'b1;
                f  = fn_q;
            end
            WB: begin
                w  = 1'b1;
                l3 = 1'b1;
                s2 = dst_q;
            end
            ACK: begin
                ack0 = ~gnt_q;
                ack1 = gnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dp_share_sequencer.sv
// Self-checking bench for dp_share_sequencer: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_dp_share_sequencer;

    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, fn0, fn1;
    logic [SEL_W-1:0] src_a0, src_b0, dst0, src_a1, src_b1, dst1;
    logic             ack0, ack1, busy, gnt_id, l1, l4, l2, l3, r, w, f;
    logic [SEL_W-1:0] s1, s2;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles elapsed since the grant edge (-1 = idle), owner, latched op.
    int               m_age;
    bit               m_owner;
    bit               m_last;
    logic [SEL_W-1:0] m_a, m_b, m_d;
    bit               m_f;

    always #5 clk = ~clk;

    dp_share_sequencer #(.SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .src_a0(src_a0), .src_b0(src_b0), .dst0(dst0), .fn0(fn0),
        .req1(req1), .src_a1(src_a1), .src_b1(src_b1), .dst1(dst1), .fn1(fn1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .gnt_id(gnt_id),
        .l1(l1), .l4(l4), .l2(l2), .l3(l3), .r(r), .w(w), .f(f), .s1(s1), .s2(s2)
    );

    wire [15:0] dut_vec = {ack0, ack1, busy, l1, l4, l2, l3, r, w, f, s1, s2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic             e_ack0, e_ack1, e_busy, e_l1, e_l4, e_l2, e_l3, e_r, e_w, e_f;
        logic [SEL_W-1:0] e_s1, e_s2;
        e_busy = (m_age >= 0);
        e_l1   = (m_age == 0);
        e_l4   = (m_age == 1);
        e_l2   = (m_age == 2);
        e_l3   = (m_age == 3);
        e_r    = (m_age == 0) || (m_age == 1);
        e_w    = (m_age == 3);
        e_f    = (m_age == 2) ? m_f : 1'b0;
        e_s1   = (m_age == 0) ? m_a : (m_age == 1) ? m_b : '0;
        e_s2   = (m_age == 3) ? m_d : '0;
        e_ack0 = (m_age == 4) && !m_owner;
        e_ack1 = (m_age == 4) && m_owner;
        return {e_ack0, e_ack1, e_busy, e_l1, e_l4, e_l2, e_l3, e_r, e_w, e_f, e_s1, e_s2};
    endfunction

    task automatic model_reset();
        m_age   = -1;
        m_last  = 1'b1;
        m_owner = 1'b0;
    endtask

    // Advances the model across one rising edge using the inputs held at that edge.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (m_age < 0) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? !m_last : req1;
                m_a     = m_owner ? src_a1 : src_a0;
                m_b     = m_owner ? src_b1 : src_b0;
                m_d     = m_owner ? dst1   : dst0;
                m_f     = m_owner ? fn1    : fn0;
                m_age   = 0;
            end
        end else if (m_age == 4) begin
            m_last = m_owner;
            m_age  = -1;
        end else begin
            m_age++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("outputs", {16'd0, dut_vec}, {16'd0, exp_vec()});
        if (m_age >= 0) check("gnt_id", {31'd0, gnt_id}, {31'd0, m_owner});
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_outputs", {16'd0, dut_vec}, 32'd0);
        check("rst_gnt", {31'd0, gnt_id}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_op0(input logic [SEL_W-1:0] a, b, d, input logic fn);
        src_a0 = a; src_b0 = b; dst0 = d; fn0 = fn;
    endtask

    task automatic set_op1(input logic [SEL_W-1:0] a, b, d, input logic fn);
        src_a1 = a; src_b1 = b; dst1 = d; fn1 = fn;
    endtask

    initial begin
        int expect_owner;
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        set_op0(0, 0, 0, 0);
        set_op1(0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Idle with no requests.
        repeat (3) step();

        // Single op from requester 0, operand B altered and req dropped during LD_A.
        req0 = 1; set_op0(1, 2, 5, 1);
        step();
        check("single_l1", {31'd0, l1}, 32'd1);
        req0 = 0; src_b0 = 7;
        step();
        check("opchg_s1", {29'd0, s1}, 32'd2);
        repeat (2) step();
        check("single_s2", {29'd0, s2}, 32'd5);
        step();
        check("single_ack0", {30'd0, ack0, ack1}, 32'd2);
        repeat (2) step();

        // Tie after reset: requester 0 first, then 1, grants alternating while both held.
        pulse_reset();
        req0 = 1; req1 = 1;
        set_op0(3, 4, 6, 0);
        set_op1(5, 6, 7, 1);
        expect_owner = 0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (m_age == 0) begin
                check("rr_grant", {31'd0, gnt_id}, expect_owner);
                expect_owner = 1 - expect_owner;
            end
        end
        check("rr_count", expect_owner, 0);
        req0 = 0; req1 = 0;
        repeat (6) step();

        // Reset during EXEC aborts without ack; the next tie goes to requester 0.
        req0 = 1; req1 = 0; set_op0(3, 4, 6, 1);
        repeat (3) step();
        check("mid_exec_l2", {31'd0, l2}, 32'd1);
        req0 = 0;
        pulse_reset();
        req0 = 1; req1 = 1;
        step();
        check("post_rst_tie", {31'd0, gnt_id}, 32'd0);
        req0 = 0; req1 = 0;
        repeat (6) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            set_op0(SEL_W'($urandom), SEL_W'($urandom), SEL_W'($urandom), 1'($urandom));
            set_op1(SEL_W'($urandom), SEL_W'($urandom), SEL_W'($urandom), 1'($urandom));
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
